// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared helpers and constants for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;
  localparam int RR_PTR_RESET = 0;
  localparam int N_REQ_MAX = 16;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  typedef logic [clog2_min1(N_REQ_MAX)-1:0] rr_idx_t;
endpackage

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester-side valid/ready bundle and registered output channel.
interface mux_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8
);
  localparam int IW = mux_rr_arbiter_pkg::clog2_min1(N_REQ);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IW-1:0] out_src;
  modport slave (input req_valid, req_data, out_ready, output req_ready, out_valid, out_data, out_src);
  modport master (output req_valid, req_data, out_ready, input req_ready, out_valid, out_data, out_src);
endinterface

// File: rtl/mux_rr_arbiter_pick.sv
// rr_pick: combinational round-robin scan starting at ptr, returns index, one-hot and any.
module rr_pick import mux_rr_arbiter_pkg::*; #(
  parameter int N_REQ = 4,
  localparam int IW = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    gnt_idx,
  output logic [N_REQ-1:0] gnt_oh,
  output logic             any_valid
);
  always_comb begin
    gnt_idx = '0;
    gnt_oh = '0;
    any_valid = |req;
    // descending scan so the lowest offset from ptr wins
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N_REQ]) gnt_idx = IW'((int'(ptr) + k) % N_REQ);
    gnt_oh[gnt_idx] = any_valid;
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter steering N_REQ requesters into one registered output.
// Optional accepted-transfer counter on port xfer_count under MUX_RR_ARB_STATS_EN.
module mux_rr_arbiter import mux_rr_arbiter_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  mux_rr_arbiter_if.slave bus
`ifdef MUX_RR_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] xfer_count
`endif
);
  localparam int IW = clog2_min1(N_REQ);
  typedef logic [IW-1:0] idx_t;
  idx_t ptr_q, ptr_d, out_src_q, out_src_d, gnt_idx;
  logic [N_REQ-1:0] gnt_oh;
  logic any_valid, load, accept, out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(bus.req_valid),
    .ptr(ptr_q),
    .gnt_idx(gnt_idx),
    .gnt_oh(gnt_oh),
    .any_valid(any_valid)
  );
  always_comb begin
    load = !out_valid_q || bus.out_ready;
    accept = load && any_valid;
    // rst_n gate keeps ready low while reset is held even though load is 1
    bus.req_ready = (load && rst_n) ? gnt_oh : '0;
    out_valid_d = load ? any_valid : out_valid_q;
    out_data_d = accept ? bus.req_data[gnt_idx*DATA_W +: DATA_W] : out_data_q;
    out_src_d = accept ? gnt_idx : out_src_q;
    ptr_d = !accept ? ptr_q : (gnt_idx == idx_t'(N_REQ - 1)) ? idx_t'(RR_PTR_RESET) : gnt_idx + idx_t'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_src_q <= '0;
      ptr_q <= idx_t'(RR_PTR_RESET);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_src_q <= out_src_d;
      ptr_q <= ptr_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_src = out_src_q;
`ifdef MUX_RR_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (accept && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed vector table on a 4-requester instance plus a 3-requester wrap sequence.
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mux_rr_arbiter_if #(.N_REQ(4), .DATA_W(8)) a_if ();
  mux_rr_arbiter_if #(.N_REQ(3), .DATA_W(8)) b_if ();
`ifdef MUX_RR_ARB_STATS_EN
  logic [1:0] cnt_a, cnt_b;
`endif
  mux_rr_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
`ifdef MUX_RR_ARB_STATS_EN
    , .xfer_count(cnt_a)
`endif
  );
  mux_rr_arbiter #(.N_REQ(3), .DATA_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
`ifdef MUX_RR_ARB_STATS_EN
    , .xfer_count(cnt_b)
`endif
  );
  typedef struct {
    logic [3:0] rv;
    logic [31:0] rd;
    logic ordy;
    logic [3:0] rr;
    logic ov;
    logic [7:0] od;
    logic [1:0] src;
  } vec_t;
  vec_t v[17];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    // fairness from ptr=0, single requester, idle, stall then resume
    for (int i = 0; i < 5; i++)
      v[i] = '{4'hF, 32'h30201000, 1'b1, 4'(1 << (i % 4)), 1'b1, 8'((i % 4) * 16), 2'(i % 4)};
    v[5] = '{4'h4, 32'h00A50000, 1'b1, 4'h4, 1'b1, 8'hA5, 2'd2};
    v[6] = '{4'h0, 32'h0, 1'b1, 4'h0, 1'b0, 8'hA5, 2'd2};
    v[7] = '{4'h3, 32'h00000201, 1'b1, 4'h1, 1'b1, 8'h01, 2'd0};
    for (int i = 8; i < 13; i++)
      v[i] = '{4'h3, 32'h00000201, 1'b0, 4'h0, 1'b1, 8'h01, 2'd0};
    v[13] = '{4'h3, 32'h00000201, 1'b1, 4'h2, 1'b1, 8'h02, 2'd1};
    v[14] = '{4'h3, 32'h00000201, 1'b1, 4'h1, 1'b1, 8'h01, 2'd0};
    v[15] = '{4'h0, 32'h0, 1'b0, 4'h0, 1'b1, 8'h01, 2'd0};
    v[16] = '{4'h0, 32'h0, 1'b1, 4'h0, 1'b0, 8'h01, 2'd0};
    a_if.req_valid = 4'hF;
    a_if.req_data = '0;
    a_if.out_ready = 1'b1;
    b_if.req_valid = '0;
    b_if.req_data = '0;
    b_if.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_ready", 32'(a_if.req_ready), 0);
      chk("rst_valid", 32'(a_if.out_valid), 0);
    end
    a_if.req_valid = '0;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_valid", 32'(a_if.out_valid), 0);
      chk("idle_ready", 32'(a_if.req_ready), 0);
      chk("idle_src", 32'(a_if.out_src), 0);
    end
    for (int i = 0; i < 17; i++) begin
      a_if.req_valid = v[i].rv;
      a_if.req_data = v[i].rd;
      a_if.out_ready = v[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(a_if.req_ready), 32'(v[i].rr));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(a_if.out_valid), 32'(v[i].ov));
      chk($sformatf("v%0d_data", i), 32'(a_if.out_data), 32'(v[i].od));
      chk($sformatf("v%0d_src", i), 32'(a_if.out_src), 32'(v[i].src));
    end
    // three requesters: grant 1 moves ptr to 2, then 2 and 0 alternate across the wrap
    b_if.req_data = 24'h221100;
    b_if.req_valid = 3'b010;
    #1;
    chk("b_pre_ready", 32'(b_if.req_ready), 32'h2);
    @(posedge clk); #1;
    chk("b_pre_src", 32'(b_if.out_src), 1);
    chk("b_pre_data", 32'(b_if.out_data), 32'h11);
    b_if.req_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      int e;
      e = (k % 2 == 0) ? 2 : 0;
      #1;
      chk($sformatf("b%0d_ready", k), 32'(b_if.req_ready), 32'(1 << e));
      @(posedge clk); #1;
      chk($sformatf("b%0d_src", k), 32'(b_if.out_src), 32'(e));
      chk($sformatf("b%0d_data", k), 32'(b_if.out_data), (e == 2) ? 32'h22 : 32'h00);
    end
    b_if.req_valid = '0;
    // five transfers from requester 0, then stall and reset asynchronously mid-cycle
    a_if.req_valid = 4'h1;
    a_if.req_data = 32'h0000005A;
    a_if.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("x_src", 32'(a_if.out_src), 0);
      chk("x_data", 32'(a_if.out_data), 32'h5A);
    end
    a_if.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("stall_valid", 32'(a_if.out_valid), 1);
    chk("stall_ready", 32'(a_if.req_ready), 0);
`ifdef MUX_RR_ARB_STATS_EN
    chk("cnt_sat", 32'(cnt_a), 3);
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(a_if.out_valid), 0);
    chk("arst_data", 32'(a_if.out_data), 0);
    chk("arst_src", 32'(a_if.out_src), 0);
    chk("arst_ready", 32'(a_if.req_ready), 0);
`ifdef MUX_RR_ARB_STATS_EN
    chk("arst_cnt", 32'(cnt_a), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    a_if.out_ready = 1'b1;
    #1;
    chk("post_ready", 32'(a_if.req_ready), 32'h1);
    @(posedge clk); #1;
    chk("post_src", 32'(a_if.out_src), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
